// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit owning HI/LO: shift-add multiply, restoring divide,
// WIDTH calculation cycles plus one sign-fix cycle.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sig_start,
  input  logic [1:0]       sig_op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             sig_flush,
  input  logic             sig_mthi,
  input  logic             sig_mtlo,
  input  logic [WIDTH-1:0] write_data,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] x, input logic is_signed);
    if (is_signed && x[WIDTH-1]) abs_val = -x;
    else                         abs_val = x;
  endfunction

  logic [1:0]         state_q, state_d;
  logic [1:0]         op_q, op_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d, a_raw_q, a_raw_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               neg_res_q, neg_res_d, neg_rem_q, neg_rem_d, dbz_q, dbz_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic               busy_q, busy_d, done_q, done_d, dbz_out_q, dbz_out_d;

  logic [WIDTH-1:0]   abs_a_s, abs_b_s, quo_fix_s, rem_fix_s;
  logic [WIDTH:0]     mul_sum_s, rem_shift_s, rem_diff_s;
  logic [2*WIDTH-1:0] mul_step_s, div_step_s, prod_fix_s;

  // Datapath: one multiply or divide iteration plus the final sign correction.
  always_comb begin
    abs_a_s     = abs_val(src_a, ~sig_op[0]);
    abs_b_s     = abs_val(src_b, ~sig_op[0]);
    mul_sum_s   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, a_q} : {(WIDTH+1){1'b0}});
    mul_step_s  = {mul_sum_s, acc_q[WIDTH-1:1]};
    rem_shift_s = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    rem_diff_s  = rem_shift_s - {1'b0, b_q};
    if (!rem_diff_s[WIDTH]) div_step_s = {rem_diff_s[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    else                    div_step_s = {rem_shift_s[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
    prod_fix_s  = neg_res_q ? -acc_q : acc_q;
    quo_fix_s   = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem_fix_s   = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
  end

  // Next-state logic for the control FSM and the architectural HI/LO.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    a_raw_d   = a_raw_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    dbz_d     = dbz_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    dbz_out_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (sig_mthi) hi_d = write_data;
        else          hi_d = hi_q;
        if (sig_mtlo) lo_d = write_data;
        else          lo_d = lo_q;
        if (sig_start && !sig_flush) begin
          op_d      = sig_op;
          a_d       = abs_a_s;
          b_d       = abs_b_s;
          a_raw_d   = src_a;
          // Divide keeps the dividend in the low half; multiply keeps the multiplier there.
          acc_d     = {{WIDTH{1'b0}}, (sig_op[1] ? abs_a_s : abs_b_s)};
          cnt_d     = CNT_W'(WIDTH);
          neg_res_d = ~sig_op[0] & (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
          neg_rem_d = ~sig_op[0] & src_a[WIDTH-1];
          dbz_d     = sig_op[1] & (src_b == {WIDTH{1'b0}});
          busy_d    = 1'b1;
          state_d   = S_CALC;
        end else begin
          busy_d    = 1'b0;
          state_d   = S_IDLE;
        end
      end
      S_CALC: begin
        if (sig_flush) begin
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          acc_d = op_q[1] ? div_step_s : mul_step_s;
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_d = S_FIX;
          else                    state_d = S_CALC;
        end
      end
      S_FIX: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
        if (sig_flush) begin
          done_d = 1'b0;
        end else begin
          done_d = 1'b1;
          if (!op_q[1]) begin
            hi_d = prod_fix_s[2*WIDTH-1:WIDTH];
            lo_d = prod_fix_s[WIDTH-1:0];
          end else if (dbz_q) begin
            hi_d      = a_raw_q;
            lo_d      = {WIDTH{1'b1}};
            dbz_out_d = 1'b1;
          end else begin
            hi_d = rem_fix_s;
            lo_d = quo_fix_s;
          end
        end
      end
      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      op_q      <= 2'b00;
      a_q       <= '0;
      b_q       <= '0;
      a_raw_q   <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dbz_q     <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dbz_out_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      a_q       <= a_d;
      b_q       <= b_d;
      a_raw_q   <= a_raw_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      dbz_q     <= dbz_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      dbz_out_q <= dbz_out_d;
    end
  end

  assign hi          = hi_q;
  assign lo          = lo_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dbz_out_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: expected HI/LO/div_by_zero queued at start,
// popped and checked when done pulses.
module tb_mult_div_unit;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n, sig_start, sig_flush, sig_mthi, sig_mtlo;
  logic [1:0]   sig_op;
  logic [W-1:0] src_a, src_b, write_data, hi, lo;
  logic         busy, done, div_by_zero;

  typedef struct packed {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dbz;
  } exp_t;
  exp_t sb_q[$];

  int total = 0;
  int bad   = 0;
  int busy_n;
  int done_n;

  mult_div_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .sig_start(sig_start), .sig_op(sig_op),
    .src_a(src_a), .src_b(src_b), .sig_flush(sig_flush),
    .sig_mthi(sig_mthi), .sig_mtlo(sig_mtlo), .write_data(write_data),
    .hi(hi), .lo(lo), .busy(busy), .done(done), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input bit push, input logic [W-1:0] ehi, input logic [W-1:0] elo,
                          input logic edbz);
    exp_t e;
    @(negedge clk);
    sig_op = op; src_a = a; src_b = b; sig_start = 1'b1;
    @(negedge clk);
    sig_start = 1'b0;
    if (push) begin
      e.hi = ehi; e.lo = elo; e.dbz = edbz;
      sb_q.push_back(e);
    end
  endtask

  task automatic wait_done(input string tag, output int bn);
    exp_t e;
    bit got;
    got = 1'b0;
    bn = 0;
    for (int i = 0; i < 200 && !got; i++) begin
      if (done === 1'b1) begin
        got = 1'b1;
        if (sb_q.size() == 0) begin
          check({tag, "_unexpected_done"}, 64'd1, 64'd0);
        end else begin
          e = sb_q.pop_front();
          check({tag, "_hi"}, {32'd0, hi}, {32'd0, e.hi});
          check({tag, "_lo"}, {32'd0, lo}, {32'd0, e.lo});
          check({tag, "_dbz"}, {63'd0, div_by_zero}, {63'd0, e.dbz});
          check({tag, "_busy_at_done"}, {63'd0, busy}, 64'd0);
        end
        @(negedge clk);
        check({tag, "_done_pulse"}, {63'd0, done}, 64'd0);
        check({tag, "_dbz_pulse"}, {63'd0, div_by_zero}, 64'd0);
      end else begin
        if (busy === 1'b1) bn++;
        @(negedge clk);
      end
    end
    if (!got) check({tag, "_timeout"}, 64'd0, 64'd1);
  endtask

  initial begin
    rst_n = 1'b0; sig_start = 1'b0; sig_op = 2'b00; src_a = '0; src_b = '0;
    sig_flush = 1'b0; sig_mthi = 1'b0; sig_mtlo = 1'b0; write_data = '0;
    #12;
    check("rst_hi", {32'd0, hi}, 64'd0);
    check("rst_lo", {32'd0, lo}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_dbz", {63'd0, div_by_zero}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // MULTU max*max, with latency
    start_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
    wait_done("multu_max", busy_n);
    check("multu_busy_cycles", 64'(busy_n), 64'd33);
    check("multu_done_edge", 64'(busy_n + 1), 64'd34);

    start_op(2'b00, 32'hFFFF_FFFD, 32'd7, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
    wait_done("mult_neg3x7", busy_n);
    start_op(2'b00, 32'h8000_0000, 32'h8000_0000, 1'b1, 32'h4000_0000, 32'h0, 1'b0);
    wait_done("mult_minxmin", busy_n);
    start_op(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    wait_done("div_neg7_2", busy_n);
    start_op(2'b11, 32'd7, 32'd2, 1'b1, 32'd1, 32'd3, 1'b0);
    wait_done("divu_7_2", busy_n);
    start_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h0, 32'h8000_0000, 1'b0);
    wait_done("div_ovf", busy_n);
    start_op(2'b11, 32'd5, 32'd0, 1'b1, 32'd5, 32'hFFFF_FFFF, 1'b1);
    wait_done("divu_by0", busy_n);
    check("divu_by0_busy_cycles", 64'(busy_n), 64'd33);
    start_op(2'b11, 32'd9, 32'd3, 1'b1, 32'd0, 32'd3, 1'b0);
    wait_done("divu_9_3", busy_n);

    // MTHI/MTLO preload in IDLE
    sig_mthi = 1'b1; sig_mtlo = 1'b0; write_data = 32'h11;
    @(negedge clk);
    sig_mthi = 1'b0; sig_mtlo = 1'b1; write_data = 32'h22;
    @(negedge clk);
    sig_mtlo = 1'b0;
    check("mthi", {32'd0, hi}, 64'h11);
    check("mtlo", {32'd0, lo}, 64'h22);

    // Flush mid-CALC
    start_op(2'b01, 32'd6, 32'd7, 1'b0, '0, '0, 1'b0);
    repeat (9) @(negedge clk);
    sig_flush = 1'b1;
    @(negedge clk);
    sig_flush = 1'b0;
    check("flush_busy", {63'd0, busy}, 64'd0);
    done_n = 0;
    for (int i = 0; i < 40; i++) begin
      if (done === 1'b1) done_n++;
      @(negedge clk);
    end
    check("flush_no_done", 64'(done_n), 64'd0);
    check("flush_hi", {32'd0, hi}, 64'h11);
    check("flush_lo", {32'd0, lo}, 64'h22);

    // Start while busy is ignored
    start_op(2'b01, 32'd6, 32'd7, 1'b1, 32'd0, 32'd42, 1'b0);
    repeat (5) @(negedge clk);
    sig_op = 2'b11; src_a = 32'd100; src_b = 32'd3; sig_start = 1'b1;
    @(negedge clk);
    sig_start = 1'b0;
    wait_done("restart_6x7", busy_n);
    done_n = 0;
    for (int i = 0; i < 40; i++) begin
      if (done === 1'b1) done_n++;
      @(negedge clk);
    end
    check("no_second_done", 64'(done_n), 64'd0);

    // Asynchronous reset mid-CALC
    start_op(2'b01, 32'd6, 32'd7, 1'b0, '0, '0, 1'b0);
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_hi", {32'd0, hi}, 64'd0);
    check("arst_lo", {32'd0, lo}, 64'd0);
    check("arst_busy", {63'd0, busy}, 64'd0);
    check("arst_done", {63'd0, done}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // MTHI while busy is ignored
    start_op(2'b11, 32'd100, 32'd7, 1'b1, 32'd2, 32'd14, 1'b0);
    sig_mthi = 1'b1; write_data = 32'hAA;
    repeat (5) @(negedge clk);
    sig_mthi = 1'b0;
    wait_done("divu_100_7", busy_n);

    check("scoreboard_empty", 64'(sb_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
